mantissa_addsub_pipe: RTL and testbench

MANTISSA_ADDSUB_PIPE -- requirements
Module: mantissa_addsub_pipe

---
 rtl/FPU_192_Package.sv | 42 ++++
 rtl/mantissa_addsub_pipe_if.sv | 28 ++
 rtl/addsub_pipe_stage.sv | 39 +++
 rtl/mantissa_addsub_pipe.sv | 129 ++++++++++++
 tb/tb_mantissa_addsub_pipe.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/FPU_192_Package.sv
// Shared constants, result record and carry-lookahead helper for the
// signed-magnitude mantissa adder/subtractor.
package FPU_192_Package;

  localparam int MAN_W_DEF  = 24;
  localparam int STAGES_DEF = 2;
  localparam int MAN_W_MAX  = 64;

  // Result field is sized for the widest legal mantissa; narrower builds zero-extend.
  typedef struct packed {
    logic                 sign_r;
    logic                 cout;
    logic                 zero;
    logic [MAN_W_MAX-1:0] result;
  } addsub_result_t;

  // 4-bit lookahead blocks chained by block generate/propagate.
  // Returns {carry_out, sum}; operands narrower than 64 bits are zero-extended,
  // so the carry out of bit w-1 also appears as sum bit w.
  function automatic logic [MAN_W_MAX:0] cla_add(input logic [MAN_W_MAX-1:0] a,
                                                 input logic [MAN_W_MAX-1:0] b,
                                                 input logic                 cin);
    logic [MAN_W_MAX-1:0] g;
    logic [MAN_W_MAX-1:0] p;
    logic [MAN_W_MAX:0]   c;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < MAN_W_MAX; k += 4) begin
      c[k+1] = g[k] | (p[k] & c[k]);
      c[k+2] = g[k+1] | (p[k+1] & g[k]) | (p[k+1] & p[k] & c[k]);
      c[k+3] = g[k+2] | (p[k+2] & g[k+1]) | (p[k+2] & p[k+1] & g[k])
             | (p[k+2] & p[k+1] & p[k] & c[k]);
      c[k+4] = g[k+3] | (p[k+3] & g[k+2]) | (p[k+3] & p[k+2] & g[k+1])
             | (p[k+3] & p[k+2] & p[k+1] & g[k])
             | (p[k+3] & p[k+2] & p[k+1] & p[k] & c[k]);
    end
    return {c[MAN_W_MAX], p ^ c[MAN_W_MAX-1:0]};
  endfunction

endpackage

// File: rtl/mantissa_addsub_pipe_if.sv
// Operand/result handshake bundle for mantissa_addsub_pipe.
interface mantissa_addsub_pipe_if #(
  parameter int MAN_W = FPU_192_Package::MAN_W_DEF
);
  logic             in_valid;
  logic             in_ready;
  logic [MAN_W-1:0] man_x;
  logic [MAN_W-1:0] man_y;
  logic             sign_x;
  logic             sign_y;
  logic             add_sub;
  logic             out_valid;
  logic             out_ready;
  logic [MAN_W-1:0] result;
  logic             cout;
  logic             sign_r;
  logic             zero;

  modport master (
    output in_valid, man_x, man_y, sign_x, sign_y, add_sub, out_ready,
    input  in_ready, out_valid, result, cout, sign_r, zero
  );

  modport slave (
    input  in_valid, man_x, man_y, sign_x, sign_y, add_sub, out_ready,
    output in_ready, out_valid, result, cout, sign_r, zero
  );
endinterface

// File: rtl/addsub_pipe_stage.sv
// One valid/ready register slice; loads when empty or when its successor
// takes the current entry in the same cycle.
module addsub_pipe_stage #(
  parameter int WIDTH      = 8,
  parameter bit RESET_DATA = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  assign in_ready  = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_data  = data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        valid_reg <= 1'b0;
    else if (in_ready) valid_reg <= in_valid;
  end

  // Only the slice that drives the block outputs needs a defined reset value.
  if (RESET_DATA) begin : g_rst
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     data_reg <= '0;
      else if (in_ready && in_valid) data_reg <= in_data;
    end
  end else begin : g_norst
    always_ff @(posedge clk) begin
      if (in_ready && in_valid) data_reg <= in_data;
    end
  end
endmodule

// File: rtl/mantissa_addsub_pipe.sv
// Pipelined signed-magnitude mantissa add/subtract: swap so the larger
// magnitude is the minuend, then a split carry-lookahead add.
module mantissa_addsub_pipe
  import FPU_192_Package::*;
#(
  parameter int MAN_W  = MAN_W_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input logic                   clk,
  input logic                   rst_n,
  mantissa_addsub_pipe_if.slave bus
);
  localparam int LO    = MAN_W / 2;
  localparam int HI    = MAN_W - LO;
  localparam int RES_W = $bits(addsub_result_t);
  localparam int MID_W = 2 * MAN_W + 3;
  localparam int DW    = (MID_W > RES_W) ? MID_W : RES_W;

  // Between the low-half and high-half add: a holds {a_hi, low sum}.
  typedef struct packed {
    logic             sign;
    logic             eff_sub;
    logic             carry;
    logic [MAN_W-1:0] a;
    logic [MAN_W-1:0] b;
  } mid_t;

  function automatic addsub_result_t pack_result(input logic eff, input logic sign,
                                                 input logic carry, input logic [MAN_W-1:0] sum);
    addsub_result_t r;
    r        = '0;
    r.result = MAN_W_MAX'(sum);
    r.cout   = carry & ~eff;
    r.zero   = (sum == '0) && !r.cout;
    r.sign_r = sign & ~r.zero;
    return r;
  endfunction

  logic             eff_sub;
  logic             swap;
  logic [MAN_W-1:0] op_big;
  logic [MAN_W-1:0] op_small;
  logic [MAN_W-1:0] op_b;

  always_comb begin
    eff_sub  = bus.sign_x ^ bus.sign_y ^ bus.add_sub;
    swap     = eff_sub && (bus.man_x < bus.man_y);
    op_big   = swap ? bus.man_y : bus.man_x;
    op_small = swap ? bus.man_x : bus.man_y;
    op_b     = eff_sub ? ~op_small : op_small;
  end

  logic [STAGES:0] valid_c;
  logic [STAGES:0] ready_c;
  logic [DW-1:0]   d_in  [STAGES];
  logic [DW-1:0]   d_out [STAGES];

  assign valid_c[0]      = bus.in_valid;
  assign bus.in_ready    = ready_c[0];
  assign ready_c[STAGES] = bus.out_ready;
  assign bus.out_valid   = valid_c[STAGES];

  if (STAGES == 1) begin : g_single
    logic [MAN_W_MAX:0] full_sum;
    addsub_result_t     res_next;
    always_comb begin
      full_sum = cla_add(MAN_W_MAX'(op_big), MAN_W_MAX'(op_b), eff_sub);
      res_next = pack_result(eff_sub, bus.sign_x ^ swap, full_sum[MAN_W], full_sum[MAN_W-1:0]);
    end
    assign d_in[0] = DW'(res_next);
    logic unused_sum;
    assign unused_sum = ^full_sum;
  end else begin : g_split
    logic [MAN_W_MAX:0] lo_sum;
    logic [MAN_W_MAX:0] hi_sum;
    mid_t               mid_next;
    mid_t               mid_q;
    addsub_result_t     res_next;
    always_comb begin
      lo_sum           = cla_add(MAN_W_MAX'(op_big[LO-1:0]), MAN_W_MAX'(op_b[LO-1:0]), eff_sub);
      mid_next.sign    = bus.sign_x ^ swap;
      mid_next.eff_sub = eff_sub;
      mid_next.carry   = lo_sum[LO];
      mid_next.a       = {op_big[MAN_W-1:LO], lo_sum[LO-1:0]};
      mid_next.b       = {op_b[MAN_W-1:LO], {LO{1'b0}}};
      mid_q            = mid_t'(d_out[0][MID_W-1:0]);
      hi_sum           = cla_add(MAN_W_MAX'(mid_q.a[MAN_W-1:LO]), MAN_W_MAX'(mid_q.b[MAN_W-1:LO]),
                                 mid_q.carry);
      res_next         = pack_result(mid_q.eff_sub, mid_q.sign, hi_sum[HI],
                                     {hi_sum[HI-1:0], mid_q.a[LO-1:0]});
    end
    assign d_in[0] = DW'(mid_next);
    assign d_in[1] = DW'(res_next);
    logic unused_mid;
    assign unused_mid = ^{lo_sum, hi_sum, mid_q.b[LO-1:0]};
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    addsub_pipe_stage #(
      .WIDTH      (DW),
      .RESET_DATA (gi == STAGES - 1)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (valid_c[gi]),
      .in_ready  (ready_c[gi]),
      .in_data   (d_in[gi]),
      .out_valid (valid_c[gi+1]),
      .out_ready (ready_c[gi+1]),
      .out_data  (d_out[gi])
    );
    // Stages past the adder only rebalance timing.
    if (gi >= 2) begin : g_balance
      assign d_in[gi] = d_out[gi-1];
    end
    logic unused_data;
    assign unused_data = ^d_out[gi];
  end

  addsub_result_t r_out;
  assign r_out      = addsub_result_t'(d_out[STAGES-1][RES_W-1:0]);
  assign bus.result = r_out.result[MAN_W-1:0];
  assign bus.cout   = r_out.cout;
  assign bus.sign_r = r_out.sign_r;
  assign bus.zero   = r_out.zero;

  logic unused_res;
  assign unused_res = ^r_out;
endmodule

// File: tb/tb_mantissa_addsub_pipe.sv
// Directed and streamed checks of mantissa_addsub_pipe with the default
// 24-bit mantissa and two pipeline stages.
module tb_mantissa_addsub_pipe;
  localparam int MAN_W  = 24;
  localparam int STAGES = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec  = 0;
  int   n_miss = 0;

  mantissa_addsub_pipe_if #(.MAN_W(MAN_W)) bus ();

  mantissa_addsub_pipe #(.MAN_W(MAN_W), .STAGES(STAGES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [26:0] ref_model(input logic sx, input logic sy, input logic as,
                                            input logic [23:0] x, input logic [23:0] y);
    logic [24:0] s;
    logic        sign;
    logic        zero;
    if ((sx ^ sy ^ as) == 1'b0) begin
      s    = {1'b0, x} + {1'b0, y};
      sign = sx;
    end else if (x >= y) begin
      s    = {1'b0, x - y};
      sign = sx;
    end else begin
      s    = {1'b0, y - x};
      sign = ~sx;
    end
    zero = (s == 25'd0);
    if (zero) sign = 1'b0;
    return {sign, s[24], zero, s[23:0]};
  endfunction

  task automatic set_op(input logic sx, input logic sy, input logic as,
                        input logic [23:0] x, input logic [23:0] y);
    bus.sign_x  = sx;
    bus.sign_y  = sy;
    bus.add_sub = as;
    bus.man_x   = x;
    bus.man_y   = y;
  endtask

  task automatic run_op(input string tag, input logic sx, input logic sy, input logic as,
                        input logic [23:0] x, input logic [23:0] y, input logic [23:0] exp_res,
                        input logic exp_cout, input logic exp_sign, input logic exp_zero);
    int lat;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    set_op(sx, sy, as, x, y);
    #1;
    check_value({tag, ".in_ready"}, bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check_value({tag, ".latency"}, lat, STAGES);
    check_value({tag, ".result"}, bus.result, exp_res);
    check_value({tag, ".cout"}, bus.cout, exp_cout);
    check_value({tag, ".sign_r"}, bus.sign_r, exp_sign);
    check_value({tag, ".zero"}, bus.zero, exp_zero);
    $display("op %-10s x=%h y=%h sx=%b sy=%b as=%b -> result=%h cout=%b sign=%b zero=%b lat=%0d",
             tag, x, y, sx, sy, as, bus.result, bus.cout, bus.sign_r, bus.zero, lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] st_x  [10];
    logic [23:0] st_y  [10];
    logic        st_sx [10];
    logic        st_sy [10];
    logic        st_as [10];
    logic [26:0] expq  [$];
    logic [26:0] got;
    logic [26:0] held;
    logic [26:0] exp_v;
    logic        held_valid;
    int          sent;
    int          recv;
    int          cyc;
    int          occ;
    int          stale;

    rst_n = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 24'h0, 24'h0);

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check_value("rst.out_valid", bus.out_valid, 0);
    check_value("rst.in_ready", bus.in_ready, 1);
    check_value("rst.result", bus.result, 0);
    check_value("rst.cout", bus.cout, 0);
    check_value("rst.sign_r", bus.sign_r, 0);
    check_value("rst.zero", bus.zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    run_op("add_pp",     1'b0, 1'b0, 1'b0, 24'hB30967, 24'h4AD278, 24'hFDDBDF, 1'b0, 1'b0, 1'b0);
    run_op("sub_pp",     1'b0, 1'b0, 1'b1, 24'hB30967, 24'h4AD278, 24'h6836EF, 1'b0, 1'b0, 1'b0);
    run_op("sub_np",     1'b1, 1'b0, 1'b1, 24'hB30967, 24'h4AD278, 24'hFDDBDF, 1'b0, 1'b1, 1'b0);
    run_op("add_nn",     1'b1, 1'b1, 1'b0, 24'hB30967, 24'h8FA6E1, 24'h42B048, 1'b1, 1'b1, 1'b0);
    run_op("sub_nn",     1'b1, 1'b1, 1'b1, 24'hB30967, 24'h8FA6E1, 24'h236286, 1'b0, 1'b1, 1'b0);
    run_op("sub_swap",   1'b0, 1'b0, 1'b1, 24'h580000, 24'h800000, 24'h280000, 1'b0, 1'b1, 1'b0);
    run_op("sub_eq",     1'b0, 1'b0, 1'b1, 24'h940000, 24'h940000, 24'h000000, 1'b0, 1'b0, 1'b1);
    run_op("sub_eq_neg", 1'b1, 1'b1, 1'b1, 24'h940000, 24'h940000, 24'h000000, 1'b0, 1'b0, 1'b1);
    run_op("add_midc",   1'b0, 1'b0, 1'b0, 24'h000FFF, 24'h000001, 24'h001000, 1'b0, 1'b0, 1'b0);
    run_op("sub_midb",   1'b1, 1'b0, 1'b0, 24'h001000, 24'h000001, 24'h000FFF, 1'b0, 1'b1, 1'b0);
    run_op("add_wrap",   1'b0, 1'b0, 1'b0, 24'h800000, 24'h800000, 24'h000000, 1'b1, 1'b0, 1'b0);

    // Random stream with random back-pressure
    for (int i = 0; i < 10; i++) begin
      st_x[i]  = 24'($urandom);
      st_y[i]  = (i % 4 == 3) ? st_x[i] : 24'($urandom);
      st_sx[i] = 1'($urandom_range(0, 1));
      st_sy[i] = 1'($urandom_range(0, 1));
      st_as[i] = 1'($urandom_range(0, 1));
    end
    sent = 0;
    recv = 0;
    cyc  = 0;
    held_valid = 1'b0;
    held = '0;
    while (recv < 10 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      bus.out_ready = 1'($urandom_range(0, 1));
      if (sent < 10) begin
        bus.in_valid = 1'b1;
        set_op(st_sx[sent], st_sy[sent], st_as[sent], st_x[sent], st_y[sent]);
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      got = {bus.sign_r, bus.cout, bus.zero, bus.result};
      occ = sent - recv;
      if (held_valid) begin
        check_value("stall.out_valid", bus.out_valid, 1);
        check_value("stall.data", got, held);
      end
      check_value("stream.in_ready", bus.in_ready, !(occ == STAGES && !bus.out_ready));
      if (bus.out_valid) check_value("stream.occupied", occ > 0, 1);
      if (bus.out_valid && bus.out_ready && expq.size() > 0) begin
        exp_v = expq.pop_front();
        check_value($sformatf("stream%0d", recv), got, exp_v);
        $display("stream out %0d: result=%h cout=%b sign=%b zero=%b (expected %h)",
                 recv, bus.result, bus.cout, bus.sign_r, bus.zero, exp_v);
        recv++;
      end
      held_valid = bus.out_valid && !bus.out_ready;
      held = got;
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(ref_model(st_sx[sent], st_sy[sent], st_as[sent], st_x[sent], st_y[sent]));
        sent++;
      end
    end
    check_value("stream.count", recv, 10);

    // Reset with a full pipeline
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < STAGES; i++) begin
      set_op(1'b0, 1'b0, 1'b0, 24'(24'h111111 * (i + 1)), 24'h000022);
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    #1;
    check_value("full.out_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_value("midrst.out_valid", bus.out_valid, 0);
    check_value("midrst.in_ready", bus.in_ready, 1);
    check_value("midrst.result", bus.result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    stale = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    check_value("midrst.stale", stale, 0);
    $display("reset with %0d ops in flight: stale outputs after release = %0d", STAGES, stale);
    run_op("post_rst", 1'b0, 1'b0, 1'b0, 24'h123456, 24'h000001, 24'h123457, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
